cpu: RTL and testbench

CPU -- requirements
Module: cpu

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/cpu_alu.sv | 46 ++++
 rtl/cpu.sv | 216 +++++++++++++++++++++
 tb/tb_cpu.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the small byte-coded CPU.
// Holds the opcode constants, operand/destination codes, the run-state
// enum and two opcode classification helpers used by the top and the ALU.
package cpu_pkg;

    // ALU opcodes (opcode[5:0])
    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_NOT  = 6'd4;
    localparam logic [5:0] OP_XOR  = 6'd5;
    localparam logic [5:0] OP_SHL  = 6'd6;
    localparam logic [5:0] OP_SHR  = 6'd7;
    localparam logic [5:0] OP_MUL  = 6'd8;
    localparam logic [5:0] OP_DIV  = 6'd9;
    localparam logic [5:0] OP_MOD  = 6'd10;

    // Conditional branch opcodes
    localparam logic [5:0] OP_EQ   = 6'h20;
    localparam logic [5:0] OP_NE   = 6'h21;
    localparam logic [5:0] OP_LT   = 6'h22;
    localparam logic [5:0] OP_LE   = 6'h23;
    localparam logic [5:0] OP_GT   = 6'h24;
    localparam logic [5:0] OP_GE   = 6'h25;

    localparam logic [5:0] OP_HALT = 6'h32;

    // Operand source codes: 0..5 select reg0..reg5
    localparam logic [7:0] NUM_REGS = 8'd6;
    localparam logic [7:0] SRC_CNT  = 8'd6;
    localparam logic [7:0] SRC_IN   = 8'd7;

    // ALU destination codes: 0..5 select reg0..reg5
    localparam logic [7:0] DST_PC   = 8'd6;
    localparam logic [7:0] DST_OUT  = 8'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_SLOW = 2'd2,
        ST_FAST = 2'd3
    } run_state_e;

    function automatic logic is_alu_op(input logic [5:0] op);
        return op <= OP_MOD;
    endfunction

    function automatic logic is_cond_op(input logic [5:0] op);
        return (op >= OP_EQ) && (op <= OP_GE);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU and comparator.
// Ports: op_i (opcode[5:0]), a_i/b_i (8-bit operands),
//        res_o (8-bit wrapped ALU result), flag_o (condition true).
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] res_o,
    output logic       flag_o
);

    always_comb begin
        res_o = 8'h00;
        case (op_i)
            OP_ADD: res_o = a_i + b_i;
            OP_SUB: res_o = a_i - b_i;
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_NOT: res_o = ~a_i;
            OP_XOR: res_o = a_i ^ b_i;
            // Shift amounts of 8 or more clear the value entirely
            OP_SHL: res_o = (b_i >= 8'd8) ? 8'h00 : (a_i << b_i[2:0]);
            OP_SHR: res_o = (b_i >= 8'd8) ? 8'h00 : (a_i >> b_i[2:0]);
            OP_MUL: res_o = a_i * b_i;
            OP_DIV: res_o = (b_i == 8'h00) ? 8'hFF : (a_i / b_i);
            OP_MOD: res_o = (b_i == 8'h00) ? a_i : (a_i % b_i);
            default: res_o = 8'h00;
        endcase
    end

    always_comb begin
        flag_o = 1'b0;
        case (op_i)
            OP_EQ: flag_o = (a_i == b_i);
            OP_NE: flag_o = (a_i != b_i);
            OP_LT: flag_o = (a_i <  b_i);
            OP_LE: flag_o = (a_i <= b_i);
            OP_GT: flag_o = (a_i >  b_i);
            OP_GE: flag_o = (a_i >= b_i);
            default: flag_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu.sv
// Byte-coded CPU with four editable 256-byte program banks.
// Ports:
//   clk, rst                 clock, synchronous active-high machine reset
//   rstROM                   synchronous clear of all program banks
//   NEXT, RUN, SPEEDRUN      step / slow run / fast run (rising-edge)
//   edit, unit, code, send   edit mode, address, data, write strobe
//   program_i                bank select for editing and execution
//   I, O, IEnable, OEnable   input bus, output bus and their strobes
//   *_monitor_signal         live reg0..reg5, PC and last output value
module cpu
    import cpu_pkg::*;
#(
    parameter int SLOW_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rstROM,
    input  logic       NEXT,
    input  logic       RUN,
    input  logic       SPEEDRUN,
    input  logic       edit,
    input  logic [7:0] unit,
    input  logic [7:0] code,
    input  logic       send,
    input  logic [1:0] program_i,
    input  logic [7:0] I,
    output logic [7:0] O,
    output logic       IEnable,
    output logic       OEnable,
    output logic [7:0] reg0_monitor_signal,
    output logic [7:0] reg1_monitor_signal,
    output logic [7:0] reg2_monitor_signal,
    output logic [7:0] reg3_monitor_signal,
    output logic [7:0] reg4_monitor_signal,
    output logic [7:0] reg5_monitor_signal,
    output logic [7:0] counter_monitor_signal,
    output logic [7:0] O_monitor_signal
);

    localparam int DIV_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOW_DIV - 1);

    run_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       regs_q [0:5];
    logic [7:0]       pc_q;
    logic [7:0]       omon_q;
    logic             next_prev_q, run_prev_q, speed_prev_q, send_prev_q;
    logic [7:0]       rom_q [0:1023];

    logic next_edge, run_edge, speed_edge, send_edge;
    logic exec;
    logic [7:0] opcode, arg1, arg2, dest;
    logic [7:0] pc1, pc2, pc3;
    logic [5:0] op;
    logic       alu_op, cond_op, halt_op;
    logic [7:0] a_val, b_val, alu_res;
    logic       cond_flag;

    assign next_edge  = NEXT     & ~next_prev_q;
    assign run_edge   = RUN      & ~run_prev_q;
    assign speed_edge = SPEEDRUN & ~speed_prev_q;
    assign send_edge  = send     & ~send_prev_q;

    // Program memory: cleared by rstROM, written only in edit mode
    always_ff @(posedge clk) begin
        if (rstROM) begin
            for (int i = 0; i < 1024; i++) rom_q[i] <= 8'h00;
        end else if (edit && send_edge) begin
            rom_q[{program_i, unit}] <= code;
        end
    end

    // Instruction fetch; the 4-byte window wraps inside the bank
    assign pc1    = pc_q + 8'd1;
    assign pc2    = pc_q + 8'd2;
    assign pc3    = pc_q + 8'd3;
    assign opcode = rom_q[{program_i, pc_q}];
    assign arg1   = rom_q[{program_i, pc1}];
    assign arg2   = rom_q[{program_i, pc2}];
    assign dest   = rom_q[{program_i, pc3}];

    assign op      = opcode[5:0];
    assign alu_op  = is_alu_op(op);
    assign cond_op = is_cond_op(op);
    assign halt_op = (op == OP_HALT);

    // Operand select: opcode bit7/bit6 turn arg1/arg2 into immediates
    always_comb begin
        a_val = 8'h00;
        if (opcode[7])               a_val = arg1;
        else if (arg1 < NUM_REGS)    a_val = regs_q[arg1[2:0]];
        else if (arg1 == SRC_CNT)    a_val = pc_q;
        else if (arg1 == SRC_IN)     a_val = I;
    end

    always_comb begin
        b_val = 8'h00;
        if (opcode[6])               b_val = arg2;
        else if (arg2 < NUM_REGS)    b_val = regs_q[arg2[2:0]];
        else if (arg2 == SRC_CNT)    b_val = pc_q;
        else if (arg2 == SRC_IN)     b_val = I;
    end

    cpu_alu u_alu (
        .op_i   (op),
        .a_i    (a_val),
        .b_i    (b_val),
        .res_o  (alu_res),
        .flag_o (cond_flag)
    );

    // Run FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Run FSM: next state
    always_comb begin
        state_d = state_q;
        if (edit) begin
            state_d = ST_IDLE;
        end else if (exec && halt_op) begin
            state_d = ST_IDLE;
        end else if (speed_edge) begin
            state_d = ST_FAST;
        end else if (run_edge) begin
            state_d = ST_SLOW;
        end else begin
            case (state_q)
                ST_IDLE: if (next_edge) state_d = ST_STEP;
                ST_STEP: state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Run FSM: outputs (execute enable)
    always_comb begin
        exec = 1'b0;
        if (!rst && !edit) begin
            case (state_q)
                ST_STEP: exec = 1'b1;
                ST_SLOW: exec = (div_q == DIV_LAST);
                ST_FAST: exec = 1'b1;
                default: exec = 1'b0;
            endcase
        end
    end

    // Divider restarts on every (re)entry into SLOW
    always_comb begin
        div_d = '0;
        if (state_d == ST_SLOW && state_q == ST_SLOW && !run_edge)
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            next_prev_q  <= 1'b0;
            run_prev_q   <= 1'b0;
            speed_prev_q <= 1'b0;
            send_prev_q  <= 1'b0;
        end else begin
            div_q        <= div_d;
            next_prev_q  <= NEXT;
            run_prev_q   <= RUN;
            speed_prev_q <= SPEEDRUN;
            send_prev_q  <= send;
        end
    end

    // Architectural state update, one instruction per execute cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) regs_q[i] <= 8'h00;
            pc_q   <= 8'h00;
            omon_q <= 8'h00;
        end else if (exec) begin
            if (alu_op) begin
                for (int i = 0; i < 6; i++)
                    if (dest == 8'(i)) regs_q[i] <= alu_res;
                if (dest == DST_OUT) omon_q <= alu_res;
                pc_q <= (dest == DST_PC) ? alu_res : pc_q + 8'd4;
            end else if (cond_op) begin
                pc_q <= cond_flag ? dest : pc_q + 8'd4;
            end else if (!halt_op) begin
                pc_q <= pc_q + 8'd4;
            end
        end
    end

    // I/O strobes; NOT has no second operand so it never reads I through arg2
    always_comb begin
        IEnable = 1'b0;
        if (exec && (alu_op || cond_op)) begin
            if (!opcode[7] && arg1 == SRC_IN) IEnable = 1'b1;
            if (!opcode[6] && arg2 == SRC_IN && op != OP_NOT) IEnable = 1'b1;
        end
    end

    assign OEnable = exec && alu_op && (dest == DST_OUT);
    assign O       = OEnable ? alu_res : 8'h00;

    assign reg0_monitor_signal    = regs_q[0];
    assign reg1_monitor_signal    = regs_q[1];
    assign reg2_monitor_signal    = regs_q[2];
    assign reg3_monitor_signal    = regs_q[3];
    assign reg4_monitor_signal    = regs_q[4];
    assign reg5_monitor_signal    = regs_q[5];
    assign counter_monitor_signal = pc_q;
    assign O_monitor_signal       = omon_q;

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst, rstROM, NEXT, RUN, SPEEDRUN, edit, send;
    logic [7:0] unit, code, I;
    logic [1:0] program_i;
    logic [7:0] O;
    logic       IEnable, OEnable;
    logic [7:0] r0, r1, r2, r3, r4, r5, pc, omon;

    int n_checks = 0;
    int n_pass   = 0;

    cpu #(.SLOW_DIV(4)) dut (
        .clk(clk), .rst(rst), .rstROM(rstROM),
        .NEXT(NEXT), .RUN(RUN), .SPEEDRUN(SPEEDRUN),
        .edit(edit), .unit(unit), .code(code), .send(send),
        .program_i(program_i), .I(I), .O(O),
        .IEnable(IEnable), .OEnable(OEnable),
        .reg0_monitor_signal(r0), .reg1_monitor_signal(r1),
        .reg2_monitor_signal(r2), .reg3_monitor_signal(r3),
        .reg4_monitor_signal(r4), .reg5_monitor_signal(r5),
        .counter_monitor_signal(pc), .O_monitor_signal(omon)
    );

    always #5 clk = ~clk;

    // Arithmetic program, bank 0
    logic [7:0] prog_arith [32] = '{
        8'h00, 8'h07, 8'h07, 8'h00,   // ADD IN IN  -> R0
        8'h01, 8'h00, 8'h07, 8'h01,   // SUB R0 IN  -> R1
        8'h02, 8'h00, 8'h01, 8'h02,   // AND R0 R1  -> R2
        8'h03, 8'h01, 8'h02, 8'h03,   // OR  R1 R2  -> R3
        8'h04, 8'h02, 8'h00, 8'h04,   // NOT R2     -> R4
        8'h05, 8'h03, 8'h04, 8'h05,   // XOR R3 R4  -> R5
        8'h00, 8'h00, 8'h00, 8'h07,   // ADD R0 R0  -> OUT
        8'h32, 8'h00, 8'h00, 8'h00    // HALT
    };

    // Boundary-case program, bank 1 (immediate operands)
    logic [7:0] prog_edge [44] = '{
        8'hC9, 8'h07, 8'h00, 8'h00,   // DIV 7/0     -> R0 = FF
        8'hCA, 8'h07, 8'h00, 8'h01,   // remainder 7%0 -> R1 = 07
        8'hC8, 8'h10, 8'h10, 8'h02,   // MUL 10*10   -> R2 = 00
        8'hC6, 8'h01, 8'h09, 8'h03,   // SHL 1 by 9  -> R3 = 00
        8'hE2, 8'h01, 8'h02, 8'h20,   // LT 1<2      -> PC = 20
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00,
        8'hE5, 8'h01, 8'h02, 8'h40,   // GE 1>=2     -> PC + 4
        8'hC7, 8'h80, 8'h07, 8'h04,   // SHR 80 by 7 -> R4 = 01
        8'h32, 8'h00, 8'h00, 8'h00    // HALT
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] bank, input logic [7:0] addr, input logic [7:0] data);
        edit = 1'b1; program_i = bank; unit = addr; code = data; send = 1'b1;
        tick(1);
        send = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic step();
        NEXT = 1'b1;
        tick(1);
        NEXT = 1'b0;
        tick(1);
    endtask

    initial begin
        int opulses;
        logic [7:0] olast;

        rst = 1'b1; rstROM = 1'b1; NEXT = 1'b0; RUN = 1'b0; SPEEDRUN = 1'b0;
        edit = 1'b0; send = 1'b0; unit = 8'h00; code = 8'h00; I = 8'h0F;
        program_i = 2'd0;
        tick(2);
        rst = 1'b0; rstROM = 1'b0;
        tick(1);

        // Reset state
        check("rst_O", O, 8'h00);
        check("rst_IEnable", IEnable, 1'b0);
        check("rst_OEnable", OEnable, 1'b0);
        check("rst_pc", pc, 8'h00);
        check("rst_r0", r0, 8'h00);
        check("rst_omon", omon, 8'h00);
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

        for (int i = 0; i < 32; i++) wr(2'd0, 8'(i), prog_arith[i]);
        for (int i = 0; i < 44; i++) wr(2'd1, 8'(i), prog_edge[i]);
        edit = 1'b0; program_i = 2'd0;
        tick(1);

        // Slow run of the arithmetic program
        RUN = 1'b1;
        tick(1);
        RUN = 1'b0;
        tick(40);
        check("run_r0", r0, 8'h1E);
        check("run_r1", r1, 8'h0F);
        check("run_r2", r2, 8'h0E);
        check("run_r3", r3, 8'h0F);
        check("run_r4", r4, 8'hF1);
        check("run_r5", r5, 8'hFE);
        check("run_omon", omon, 8'h3C);
        check("run_pc", pc, 8'h1C);
        check("run_state", 32'(dut.state_q), 32'(ST_IDLE));

        // Fast run: one instruction per clock after entry
        do_reset();
        check("rst2_r0", r0, 8'h00);
        opulses = 0; olast = 8'h00;
        SPEEDRUN = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                SPEEDRUN = 1'b0;
                check("fast_ienable", IEnable, 1'b1);
            end
            if (k == 7) check("fast_pc_k7", pc, 8'h18);
            if (k == 8) check("fast_pc_halt", pc, 8'h1C);
            if (OEnable) begin
                opulses++;
                olast = O;
            end
        end
        check("fast_opulses", opulses, 1);
        check("fast_O", olast, 8'h3C);
        check("fast_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("fast_pc_end", pc, 8'h1C);

        // Single stepping
        do_reset();
        step();
        check("step1_pc", pc, 8'h04);
        check("step1_r0", r0, 8'h1E);
        tick(3);
        check("step1_hold", pc, 8'h04);
        for (int i = 0; i < 6; i++) step();
        check("step7_pc", pc, 8'h1C);
        check("step7_r5", r5, 8'hFE);
        check("step7_omon", omon, 8'h3C);
        step();
        check("step_halt_pc", pc, 8'h1C);

        // Boundary arithmetic and conditionals, bank 1
        program_i = 2'd1;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        check("div0", r0, 8'hFF);
        check("mod0", r1, 8'h07);
        check("mul_wrap", r2, 8'h00);
        check("shl9", r3, 8'h00);
        step();
        check("lt_jump", pc, 8'h20);
        step();
        check("ge_fall", pc, 8'h24);
        step();
        check("shr7", r4, 8'h01);
        step();
        check("halt_pc", pc, 8'h28);

        // edit=1 mid-run stops execution
        program_i = 2'd0;
        do_reset();
        RUN = 1'b1;
        tick(1);
        RUN = 1'b0;
        tick(9);
        check("edit_pc_before", pc, 8'h08);
        edit = 1'b1;
        tick(12);
        check("edit_pc_hold", pc, 8'h08);
        edit = 1'b0;
        tick(12);
        check("edit_pc_after", pc, 8'h08);
        check("edit_state", 32'(dut.state_q), 32'(ST_IDLE));

        // Cleared ROM: every slot is ADD R0 R0 -> R0, PC wraps
        rstROM = 1'b1; rst = 1'b1;
        tick(1);
        rstROM = 1'b0; rst = 1'b0;
        tick(1);
        SPEEDRUN = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            if (k == 1) SPEEDRUN = 1'b0;
            if (k == 64) check("wrap_pc_fc", pc, 8'hFC);
            if (k == 66) check("wrap_pc_04", pc, 8'h04);
        end
        check("wrap_r0", r0, 8'h00);
        check("wrap_state", 32'(dut.state_q), 32'(ST_FAST));
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
